// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: fetches over a req/ack handshake, holds the
// instruction for execute, and picks the next PC (sequential, branch, call, return, halt).
module pc_sequencer #(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_data,
    output logic [PC_W-1:0] ir,
    output logic            ir_valid,
    input  logic            exec_done,
    input  logic            is_branch,
    input  logic            jump,
    input  logic            branch_rel,
    input  logic [PC_W-1:0] branch_target,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic            is_halt,
    output logic            halted,
    output logic            stack_err,
    output logic [1:0]      state_dbg
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp;

    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   branch_dest;
    logic [SP_W-1:0]   sp_dec;
    logic              stack_full;
    logic              stack_empty;
    logic              retire;

    // Handshake: imem_req is held with a stable imem_addr until the cycle imem_ack=1;
    // that cycle transfers imem_data. exec_done likewise marks the one cycle in EXEC
    // where the decode inputs are valid and consumed.
    assign pc_inc      = pc + PC_W'(1);
    assign branch_dest = branch_rel ? (pc_inc + branch_target) : branch_target;
    assign sp_dec      = sp - SP_W'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign retire      = (state == EXEC) && exec_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = FETCH;
            FETCH:   if (imem_ack)  state_nxt = EXEC;
            EXEC:    if (exec_done) state_nxt = is_halt ? HALT : FETCH;
            HALT:    if (start)     state_nxt = FETCH;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_addr = pc;
        imem_req  = (state == FETCH);
        ir_valid  = (state == EXEC);
        halted    = (state == HALT);
        state_dbg = state;
    end

    // Next-PC priority: halt, return, call, taken branch, sequential.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            if ((state == FETCH) && imem_ack) ir <= imem_data;
            if (retire) begin
                if (is_halt) begin
                    pc <= pc_inc;
                end else if (is_ret) begin
                    if (!stack_empty) begin
                        pc <= stack[sp_dec[IDX_W-1:0]];
                        sp <= sp_dec;
                    end else begin
                        stack_err <= 1'b1;
                        pc        <= pc_inc;
                    end
                end else if (is_call) begin
                    if (!stack_full) begin
                        stack[sp[IDX_W-1:0]] <= pc_inc;
                        sp                   <= sp + SP_W'(1);
                    end else begin
                        stack_err <= 1'b1;
                    end
                    pc <= branch_dest;
                end else if (is_branch && jump) begin
                    pc <= branch_dest;
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end

endmodule
